// File: rtl/tmds_gearbox_10to2.sv
// 10:2 TMDS gearbox: three 10-bit symbols per pixel period become five 8-bit DDR words (lane 3 = clock).
// Optional status counter enabled by defining TMDS_GEARBOX_STATUS_EN.
module tmds_gearbox_10to2 #(
  parameter logic [9:0] CTRL_SYM = 10'b1101010100,
  parameter logic [9:0] CLK_PAT  = 10'b0000011111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sym_valid,
  output logic        sym_ready,
  input  logic [9:0]  ch0_sym,
  input  logic [9:0]  ch1_sym,
  input  logic [9:0]  ch2_sym,
  output logic [7:0]  ddr_din,
  output logic        phase_last,
  input  logic        underflow_clr,
  output logic        underflow
`ifdef TMDS_GEARBOX_STATUS_EN
  ,
  output logic [15:0] underflow_cnt
`endif
);

  typedef logic [2:0][9:0] sym_set_t;

  logic [2:0] phase;
  logic       pend_v;
  sym_set_t   cur;
  sym_set_t   pend;
  sym_set_t   in_set;
  logic       load;
  logic       accept;
  logic       uf_load;

  assign in_set    = {ch2_sym, ch1_sym, ch0_sym};
  assign load      = (phase == 3'd4);
  assign sym_ready = !pend_v;
  assign accept    = sym_valid && !pend_v;
  assign uf_load   = load && !pend_v && !sym_valid;

  // Bit pair p of a symbol, LSB first: {D1, D0} = {s[2p+1], s[2p]}.
  function automatic logic [1:0] bit_pair(input logic [9:0] s, input logic [2:0] p);
    case (p)
      3'd0:    bit_pair = s[1:0];
      3'd1:    bit_pair = s[3:2];
      3'd2:    bit_pair = s[5:4];
      3'd3:    bit_pair = s[7:6];
      3'd4:    bit_pair = s[9:8];
      default: bit_pair = 2'b00;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase      <= 3'd0;
      phase_last <= 1'b0;
      pend_v     <= 1'b0;
      cur        <= {3{CTRL_SYM}};
      ddr_din    <= 8'h00;
      underflow  <= 1'b0;
    end else begin
      phase      <= load ? 3'd0 : phase + 3'd1;
      phase_last <= (phase == 3'd3);

      // Load priority: buffered set, then bypass of the live input, then blanking.
      if (load) begin
        if (pend_v) begin
          cur    <= pend;
          pend_v <= 1'b0;
        end else if (sym_valid) begin
          cur <= in_set;
        end else begin
          cur <= {3{CTRL_SYM}};
        end
      end else if (accept) begin
        pend_v <= 1'b1;
      end

      for (int k = 0; k < 3; k++) begin
        {ddr_din[k+4], ddr_din[k]} <= bit_pair(cur[k], phase);
      end
      {ddr_din[7], ddr_din[3]} <= bit_pair(CLK_PAT, phase);

      if (uf_load)            underflow <= 1'b1;
      else if (underflow_clr) underflow <= 1'b0;
    end
  end

  // NOTE: pend holds data only; pend_v qualifies it, so it needs no reset and stays a plain flop.
  always_ff @(posedge clk) begin
    if (accept && !load) pend <= in_set;
  end

`ifdef TMDS_GEARBOX_STATUS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow_cnt <= 16'd0;
    end else if (uf_load) begin
      if (underflow_clr)                 underflow_cnt <= 16'd1;
      else if (underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
    end else if (underflow_clr) begin
      underflow_cnt <= 16'd0;
    end
  end
`endif

endmodule

// File: tb/tb_tmds_gearbox_10to2.sv
// Scoreboard bench for tmds_gearbox_10to2: a stream-level model predicts every DDR word and status flag.
// Status counter checks are compiled in when TMDS_GEARBOX_STATUS_EN is defined.
module tb_tmds_gearbox_10to2;

  localparam logic [9:0] CTRL = 10'b1101010100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sym_valid;
  logic        sym_ready;
  logic [9:0]  ch0_sym, ch1_sym, ch2_sym;
  logic [7:0]  ddr_din;
  logic        phase_last;
  logic        underflow_clr;
  logic        underflow;
`ifdef TMDS_GEARBOX_STATUS_EN
  logic [15:0] underflow_cnt;
`endif

  tmds_gearbox_10to2 dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sym_valid     (sym_valid),
    .sym_ready     (sym_ready),
    .ch0_sym       (ch0_sym),
    .ch1_sym       (ch1_sym),
    .ch2_sym       (ch2_sym),
    .ddr_din       (ddr_din),
    .phase_last    (phase_last),
    .underflow_clr (underflow_clr),
    .underflow     (underflow)
`ifdef TMDS_GEARBOX_STATUS_EN
    ,
    .underflow_cnt (underflow_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: sets accepted but not yet transmitted, and the expected word stream.
  logic [29:0] q_pend[$];
  logic [7:0]  exp_words[$];
  int          ph;
  logic        uf_m;
  logic [15:0] cnt_m;
  bit          started;

  // A symbol set serialises into five words: pair j of each lane, lane 3 = five 1s then five 0s.
  function automatic void push_set(input logic [29:0] s);
    logic [7:0] w;
    for (int j = 0; j < 5; j++) begin
      w = 8'h00;
      for (int k = 0; k < 3; k++) begin
        w[k]   = s[k*10 + 2*j];
        w[k+4] = s[k*10 + 2*j + 1];
      end
      w[3] = (2*j < 5);
      w[7] = (2*j + 1 < 5);
      exp_words.push_back(w);
    end
  endfunction

  // Monitor: at each falling edge compare results of the last rising edge, then predict the next one.
  always @(negedge clk) begin
    logic [29:0] in_set;
    logic        uf_set;
    in_set = {ch2_sym, ch1_sym, ch0_sym};
    if (!rst_n) begin
      q_pend.delete();
      exp_words.delete();
      ph = 0; uf_m = 1'b0; cnt_m = 16'd0; started = 1'b0;
      check("rst_ddr_din", ddr_din, 8'h00);
      check("rst_sym_ready", sym_ready, 1'b1);
      check("rst_underflow", underflow, 1'b0);
      check("rst_phase_last", phase_last, 1'b0);
    end else begin
      if (!started) begin
        push_set({3{CTRL}});
        started = 1'b1;
      end else begin
        if (exp_words.size() == 0) begin
          checks++; failures++;
          $display("FAIL ddr_din: got %0h expected none (scoreboard empty) at %0t", ddr_din, $time);
        end else begin
          check("ddr_din", ddr_din, exp_words.pop_front());
        end
        check("underflow", underflow, uf_m);
`ifdef TMDS_GEARBOX_STATUS_EN
        check("underflow_cnt", underflow_cnt, cnt_m);
`endif
      end
      check("sym_ready", sym_ready, q_pend.size() == 0);
      check("phase_last", phase_last, ph == 4);

      uf_set = 1'b0;
      if (ph == 4) begin
        if (q_pend.size() != 0) push_set(q_pend.pop_front());
        else if (sym_valid)     push_set(in_set);
        else begin
          push_set({3{CTRL}});
          uf_set = 1'b1;
        end
      end else if (sym_valid && q_pend.size() == 0) begin
        q_pend.push_back(in_set);
      end

      if (uf_set) begin
        uf_m  = 1'b1;
        cnt_m = underflow_clr ? 16'd1 : (cnt_m == 16'hFFFF ? cnt_m : cnt_m + 16'd1);
      end else if (underflow_clr) begin
        uf_m  = 1'b0;
        cnt_m = 16'd0;
      end
      ph = (ph == 4) ? 0 : ph + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a set and hold it until the DUT takes it.
  task automatic send_set(input logic [29:0] s, input int gap);
    bit fire;
    int n;
    {ch2_sym, ch1_sym, ch0_sym} = s;
    sym_valid = 1'b1;
    fire = 1'b0;
    n = 0;
    while (!fire && n < 50) begin
      @(negedge clk);
      fire = sym_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!fire) begin
      checks++; failures++;
      $display("FAIL send_timeout: got sym_ready=0 for %0d cycles expected a transfer", n);
    end
    sym_valid = 1'b0;
    repeat (gap) step();
  endtask

  // Idle until the DUT sits in the given phase with the buffer empty.
  task automatic wait_phase_empty(input int p);
    int n;
    n = 0;
    while (!(ph == p && q_pend.size() == 0) && n < 40) begin
      step();
      n++;
    end
    if (n >= 40) begin
      checks++; failures++;
      $display("FAIL wait_phase: got phase %0d expected phase %0d with empty buffer", ph, p);
    end
  endtask

  function automatic logic [29:0] rand_set();
    return {$urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023)};
  endfunction

  initial begin
    rst_n = 1'b0;
    sym_valid = 1'b0;
    underflow_clr = 1'b0;
    {ch2_sym, ch1_sym, ch0_sym} = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) step();
    check("idle_underflow", underflow, 1'b1);

    // Streaming with the flag cleared first; the model checks ready and words every cycle.
    underflow_clr = 1'b1;
    step();
    underflow_clr = 1'b0;
    send_set({10'h3FF, 10'h155, 10'h2AA}, 0);
    send_set({10'h01F, 10'h3E0, 10'h000}, 0);
    for (int i = 0; i < 4; i++) send_set(rand_set(), 0);
    repeat (12) step();

    // Bypass: valid only during a load cycle with an empty buffer.
    for (int i = 0; i < 2; i++) begin
      wait_phase_empty(4);
      {ch2_sym, ch1_sym, ch0_sym} = rand_set();
      sym_valid = 1'b1;
      step();
      sym_valid = 1'b0;
      check("bypass_ready", sym_ready, 1'b1);
      repeat (6) step();
    end

    // Starve for three pixel periods after a clear at phase 0.
    wait_phase_empty(0);
    underflow_clr = 1'b1;
    step();
    underflow_clr = 1'b0;
    repeat (15) step();
    check("starve_underflow", underflow, 1'b1);
`ifdef TMDS_GEARBOX_STATUS_EN
    check("starve_cnt", underflow_cnt, 16'd3);
`endif
    // Clear coinciding with an underflow load: set wins, count restarts at 1.
    wait_phase_empty(4);
    underflow_clr = 1'b1;
    step();
    underflow_clr = 1'b0;
    check("clr_on_load_underflow", underflow, 1'b1);
`ifdef TMDS_GEARBOX_STATUS_EN
    check("clr_on_load_cnt", underflow_cnt, 16'd1);
`endif

    // Randomised traffic with random gaps and occasional clears.
    for (int i = 0; i < 30; i++) begin
      underflow_clr = ($urandom_range(0, 7) == 0);
      step();
      underflow_clr = 1'b0;
      send_set(rand_set(), $urandom_range(0, 8));
    end

    // Reset mid-symbol at phase 2 with the buffer full.
    wait_phase_empty(0);
    {ch2_sym, ch1_sym, ch0_sym} = rand_set();
    sym_valid = 1'b1;
    step();
    sym_valid = 1'b0;
    step();
    check("pre_reset_pend_full", sym_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_ddr_din", ddr_din, 8'h00);
    check("midrst_sym_ready", sym_ready, 1'b1);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (7) step();
    send_set(rand_set(), 0);
    send_set(rand_set(), 0);
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
